// File: rtl/axis_irctx_if.sv
// AXI4-Stream byte channel feeding the IRC serial transmitter.
interface axis_irctx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_irctx.sv
// IRC optical-link serial transmitter: start bit, LSB-first data, stop period,
// timed by a 16x oversampling baud tick whose divisor is captured per byte.
module axis_irctx #(
    parameter int C_DATA_BIT  = 8,
    parameter int C_STOP_TICK = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    axis_irctx_if.slave s_axis,
    input  logic [15:0] mod_m,
    output logic        tx,
    output logic        busy
);
    localparam int TW = ($clog2(C_STOP_TICK) > 4) ? $clog2(C_STOP_TICK) : 4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tick_cnt, tick_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      sr, sr_n;
    logic [15:0]     div_cnt, div_n;
    logic [15:0]     m_reg, m_n;
    logic            tx_reg, tx_n;
    logic            btick;
    logic            accept;

    assign btick         = (div_cnt == m_reg - 16'd1);
    assign s_axis.tready = aresetn && (state == S_IDLE);
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign tx            = tx_reg;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            div_cnt  <= '0;
            m_reg    <= 16'd1;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            sr       <= sr_n;
            div_cnt  <= div_n;
            m_reg    <= m_n;
            tx_reg   <= tx_n;
        end
    end

    // tx_n is the line level for the state being entered, so tx stays registered
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        sr_n    = sr;
        m_n     = m_reg;
        div_n   = btick ? '0 : div_cnt + 16'd1;
        tx_n    = tx_reg;
        case (state)
            S_IDLE: begin
                tx_n  = 1'b1;
                div_n = '0;
                if (accept) begin
                    sr_n    = s_axis.tdata;
                    m_n     = (mod_m == 16'd0) ? 16'd1 : mod_m;
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = S_START;
                    tx_n    = 1'b0;
                end
            end
            S_START: begin
                tx_n = 1'b0;
                if (btick) begin
                    if (tick_cnt == TW'(15)) begin
                        tick_n  = '0;
                        state_n = S_DATA;
                        tx_n    = sr[0];
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            S_DATA: begin
                tx_n = sr[0];
                if (btick) begin
                    if (tick_cnt == TW'(15)) begin
                        tick_n = '0;
                        sr_n   = sr >> 1;
                        if (bit_cnt == 3'(C_DATA_BIT - 1)) begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end else begin
                            bit_n = bit_cnt + 3'd1;
                            tx_n  = sr[1];
                        end
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (btick) begin
                    if (tick_cnt == TW'(C_STOP_TICK - 1)) begin
                        state_n = S_IDLE;
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: doc/axis_irctx.md
# axis_irctx

Serial transmitter for the IRC (UART-style) optical link. It accepts bytes on an AXI4-Stream slave port and serialises each one onto `tx` as a frame: start bit, data bits LSB first, stop period. Bit timing comes from an internal 16x-oversampling baud tick divider set by `mod_m`. It is the transmit counterpart of the IRC receiver and shares its framing parameters, so a `tx` -> `rx` loopback with equal `mod_m` reproduces the byte stream.

## Interface
Parameters:
- `C_DATA_BIT`, default 8: data bits per frame, range 5..8; sent from `s_axis_tdata[C_DATA_BIT-1:0]`, upper bits ignored.
- `C_STOP_TICK`, default 16: stop period length in baud ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  8  byte to transmit.
- `s_axis_tvalid`  in  1  upstream has a byte.
- `s_axis_tready`  out  1  block can accept a byte.
- `mod_m`  in  16  baud tick divisor: one tick every `mod_m` aclk cycles (bit period = 16*`mod_m`).
- `tx`  out  1  serial line output, idle high.
- `busy`  out  1  frame in progress.

## Operation
- States: S_IDLE, S_START, S_DATA, S_STOP.
- Baud divider: 16-bit counter counts 0..M-1 and wraps. `btick` is high during the cycle in which the counter equals M-1. M is `mod_m` latched at byte acceptance; a `mod_m` of 0 is treated as 1, which gives a tick every cycle. Later changes to `mod_m` do not affect the frame in progress.
- S_IDLE:
  - `s_axis_tready`=1 (gated to 0 while `aresetn`=0); `tx`=1.
  - On `s_axis_tvalid`&&`s_axis_tready`: latch the data into the shift register, latch M, clear the divider, clear the tick and bit counters, and go to S_START.
- S_START:
  - `tx`=0.
  - On each `btick`: if the tick counter = 15, clear it and go to S_DATA; otherwise increment it.
- S_DATA:
  - `tx` = shift register bit 0.
  - On each `btick` with the tick counter = 15: clear the tick counter and shift the register right by 1.
  - If the bit counter = `C_DATA_BIT`-1, go to S_STOP; otherwise increment the bit counter.
- S_STOP:
  - `tx`=1.
  - On each `btick`: if the tick counter = `C_STOP_TICK`-1, go to S_IDLE; otherwise increment it.
- `busy` = (state != S_IDLE).
- `tx` is driven from a register, so there is no combinational path from inputs to `tx`.
- Tick counter width is sufficient for `C_STOP_TICK`-1, with a minimum of 4 bits. Bit counter is 3 bits.

## Timing
- Reset values: state S_IDLE, `tx`=1, `busy`=0, `s_axis_tready`=0 while `aresetn` is low (1 from the first cycle after release), all counters 0.
- Reset asserted mid-frame: `tx` returns to 1 on the next edge and the frame is abandoned without any further output.
- Handshake accepted at edge T:
  - `tx` falls after T.
  - Start bit lasts exactly 16*M cycles.
  - Each data bit lasts exactly 16*M cycles.
  - Stop period lasts `C_STOP_TICK`*M cycles.
  - The state returns to S_IDLE at edge T + (16*(1+`C_DATA_BIT`)+`C_STOP_TICK`)*M.
- Back-to-back transfers with `s_axis_tvalid` held high: the next byte is accepted in the first S_IDLE cycle, so the line sits high for exactly 1 cycle beyond the stop period.
- `s_axis_tready` is low for the entire frame. `s_axis_tdata` and `s_axis_tvalid` are ignored while it is low.
- Throughput for the default configuration with M=8: one byte per 1281 cycles.

## Test plan
- Reset check: drive `aresetn`=0 for 5 cycles, then release with no traffic -> `tx`=1, `busy`=0, `s_axis_tready` 0 during reset and 1 after release.
- Single byte 0x55 at M=8, default parameters -> `tx` low for 128 cycles, then bits 1,0,1,0,1,0,1,0 at 128 cycles each, high for 128 cycles; `s_axis_tready` returns 1280 cycles after acceptance.
- Back-to-back 0xA3 then 0x3C with `tvalid` held high, M=4 -> second start bit begins exactly 641 cycles after the first; bit sequence 1,1,0,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- `mod_m` changed from 8 to 2 in the middle of the 0xFF frame -> the current frame keeps 128-cycle bits; the next frame uses 32-cycle bits. Also `mod_m`=0 -> identical to `mod_m`=1 (16-cycle bits).
- `aresetn` pulsed low during data bit 3 of 0x00 -> `tx`=1 on the next edge, `busy`=0, and a fresh byte 0x81 then transmits correctly.
- Loopback: connect `tx` to the IRC receiver with `C_DATA_BIT`=8 and `C_STOP_TICK`=16, send 256 bytes 0x00..0xFF -> receiver outputs an identical sequence with no drops.
